edge_event_counter: RTL



---
 rtl/edge_pkg.sv | 13 +
 rtl/edge_chan_counter.sv | 64 ++++++
 rtl/edge_event_counter.sv | 84 ++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared edge-mode encoding for the multi-channel edge event counter.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int EDGE_MODE_W = 2;

endpackage

// File: rtl/edge_chan_counter.sv
// One channel: edge detector, event counter with saturate/wrap policy and sticky overflow flag.
module edge_chan_counter
    import edge_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SIG,
    input  edge_mode_t       MODE,
    input  logic             CLR,
    output logic [WIDTH-1:0] COUNT,
    output logic             OVF
);

    logic             prev_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             rise, fall, evt;

    always_comb begin
        rise = SIG & ~prev_q;
        fall = ~SIG & prev_q;
        case (MODE)
            EDGE_RISE: evt = rise;
            EDGE_FALL: evt = fall;
            EDGE_BOTH: evt = rise | fall;
            default:   evt = 1'b0;
        endcase

        count_d = count_q;
        ovf_d   = ovf_q;
        // A clear never swallows an event landing on the same edge.
        if (CLR) begin
            count_d = evt ? WIDTH'(1) : '0;
            ovf_d   = 1'b0;
        end else if (evt) begin
            if (count_q == '1) begin
                ovf_d   = 1'b1;
                count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Reset loads the live SIG level so a line already high is not seen as a rising edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_q  <= SIG;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= SIG;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign COUNT = count_q;
    assign OVF   = ovf_q;

endmodule

// File: rtl/edge_event_counter.sv
// Multi-channel edge event counter peripheral with registered read port and clear-on-read.
module edge_event_counter
    import edge_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int WIDTH    = 8,
    parameter int SATURATE = 1,
    localparam int SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NCH-1:0]     SIG,
    input  logic [2*NCH-1:0]   EDGE_SEL,
    input  logic               RD_EN,
    input  logic [SELW-1:0]    RD_SEL,
    input  logic               RD_CLEAR,
    output logic               RD_VALID,
    output logic [WIDTH-1:0]   RD_DATA,
    output logic               RD_OVF,
    output logic               ANY_OVF
);

    logic [WIDTH-1:0] count [NCH];
    logic [NCH-1:0]   ovf;
    logic [NCH-1:0]   clr;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        edge_chan_counter #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_chan (
            .CLK   (CLK),
            .RESET (RESET),
            .SIG   (SIG[i]),
            .MODE  (edge_mode_t'(EDGE_SEL[EDGE_MODE_W*i +: EDGE_MODE_W])),
            .CLR   (clr[i]),
            .COUNT (count[i]),
            .OVF   (ovf[i])
        );
    end

    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;
    logic [WIDTH-1:0] sel_count;
    logic             sel_ovf;

    // An out-of-range RD_SEL matches no channel: reads back zero and clears nothing.
    always_comb begin
        clr       = '0;
        sel_count = '0;
        sel_ovf   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(RD_SEL) == i) begin
                clr[i]    = RD_EN & RD_CLEAR;
                sel_count = count[i];
                sel_ovf   = ovf[i];
            end
        end

        rd_valid_d = RD_EN;
        rd_data_d  = RD_EN ? sel_count : rd_data_q;
        rd_ovf_d   = RD_EN ? sel_ovf : rd_ovf_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_data_q;
    assign RD_OVF   = rd_ovf_q;
    // Flags are flops, so their OR shows the state after the current edge's update.
    assign ANY_OVF  = |ovf;

endmodule
